// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multicycle MIPS controller.
//   state_t  - controller FSM states
//   aluop_t  - ALU operation class handed from the FSM to the ALU decoder
//   OP_*     - supported opcodes (instr[31:26])
//   FN_*     - supported R-type function codes (instr[5:0])
//   ALU_*    - 3-bit ALU function codes driven on alucontrol
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: combinational translation of the FSM's ALU operation class
// and the instruction funct field into the ALU function code.
//   aluop      in  [1:0] 00 add, 01 sub, 10 decode funct
//   funct      in  [5:0] instr[5:0]
//   alucontrol out [2:0] ALU f code
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Unknown funct codes fall back to add so the instruction still
    // completes its writeback with a defined result.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit. Sequences fetch, decode,
// execute, memory and writeback, and drives all datapath enables.
//   clk, reset_n        clock, asynchronous active-low reset
//   op, funct           instruction fields from the instruction register
//   zero                ALU zero flag, used for branch decisions
//   alucontrol          ALU function code
//   alusrca, alusrcb    ALU operand selects
//   pcsrc, pcen         next-PC select and PC enable
//   iord, memwrite      memory address select and write strobe
//   irwrite             instruction register load
//   regdst, memtoreg    register file write address / data selects
//   regwrite            register file write
//   illegal_op          one-cycle pulse in DECODE for an unsupported opcode
module mc_controller
    import mc_pkg::*;
#(
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal_op
);

    state_t state, next_state;
    aluop_t aluop;

    logic pcwrite, branch;
    logic irwrite_s, memwrite_s, regwrite_s, illegal_s;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = S_FETCH;
        aluop      = ALUOP_ADD;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        illegal_s  = 1'b0;

        case (state)
            S_FETCH: begin
                irwrite_s  = 1'b1;
                alusrcb    = 2'b01;
                pcwrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_BNE: begin
                        if (ENABLE_BNE) next_state = S_BEQEX;
                        else            illegal_s  = 1'b1;
                    end
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      illegal_s  = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Branch is taken on equal for beq and on not-equal for bne; both
    // share BEQEX, so the opcode selects the sense of the zero flag.
    logic bne;
    assign bne = (op == OP_BNE);

    // State-changing strobes are gated by reset_n directly: the state
    // register already reads FETCH during reset, and FETCH would otherwise
    // load the IR and advance the PC while reset is held.
    assign irwrite    = reset_n & irwrite_s;
    assign memwrite   = reset_n & memwrite_s;
    assign regwrite   = reset_n & regwrite_s;
    assign illegal_op = reset_n & illegal_s;
    assign pcen       = reset_n & (pcwrite | (branch & (zero ^ bne)));

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench for mc_controller.
// The reference model expands each instruction into its list of per-cycle
// control vectors from the instruction's micro-operations, and every
// cycle's outputs are compared against that list.
module tb_mc_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero;

    logic [2:0] alucontrol;
    logic       alusrca, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal_op;
    logic [1:0] alusrcb, pcsrc;

    logic [2:0] nb_alucontrol;
    logic       nb_alusrca, nb_pcen, nb_iord, nb_memwrite, nb_irwrite;
    logic       nb_regdst, nb_memtoreg, nb_regwrite, nb_illegal_op;
    logic [1:0] nb_alusrcb, nb_pcsrc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller #(.ENABLE_BNE(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .illegal_op(illegal_op)
    );

    mc_controller #(.ENABLE_BNE(1'b0)) u_dut_nobne (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .alucontrol(nb_alucontrol), .alusrca(nb_alusrca), .alusrcb(nb_alusrcb),
        .pcsrc(nb_pcsrc), .pcen(nb_pcen), .iord(nb_iord), .memwrite(nb_memwrite),
        .irwrite(nb_irwrite), .regdst(nb_regdst), .memtoreg(nb_memtoreg),
        .regwrite(nb_regwrite), .illegal_op(nb_illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One expected cycle. br: 0 no branch, 1 taken when zero, 2 taken when not zero.
    typedef struct {
        logic       irwrite, pcen, iord, memwrite, alusrca, regdst, memtoreg, regwrite, illegal;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alu;
        int         br;
    } exp_t;

    exp_t plan[$];

    function automatic exp_t quiet();
        exp_t e;
        e = '{irwrite: 0, pcen: 0, iord: 0, memwrite: 0, alusrca: 0, regdst: 0,
              memtoreg: 0, regwrite: 0, illegal: 0, alusrcb: 2'b00, pcsrc: 2'b00,
              alu: 3'b010, br: 0};
        return e;
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expand one instruction into its per-cycle control vectors.
    task automatic build_plan(input logic [5:0] o, input logic [5:0] f, input bit bne_en);
        exp_t e;
        plan.delete();
        e = quiet(); e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01;
        plan.push_back(e);                                   // fetch, PC+4
        e = quiet(); e.alusrcb = 2'b11;                      // decode, branch target
        if (o == 6'b100011) begin
            plan.push_back(e);
            e = quiet(); e.alusrca = 1; e.alusrcb = 2'b10; plan.push_back(e);
            e = quiet(); e.iord = 1; plan.push_back(e);
            e = quiet(); e.regwrite = 1; e.memtoreg = 1; plan.push_back(e);
        end else if (o == 6'b101011) begin
            plan.push_back(e);
            e = quiet(); e.alusrca = 1; e.alusrcb = 2'b10; plan.push_back(e);
            e = quiet(); e.iord = 1; e.memwrite = 1; plan.push_back(e);
        end else if (o == 6'b000000) begin
            plan.push_back(e);
            e = quiet(); e.alusrca = 1; e.alu = rtype_alu(f); plan.push_back(e);
            e = quiet(); e.regdst = 1; e.regwrite = 1; plan.push_back(e);
        end else if (o == 6'b000100 || (o == 6'b000101 && bne_en)) begin
            plan.push_back(e);
            e = quiet(); e.alusrca = 1; e.alu = 3'b110; e.pcsrc = 2'b01;
            e.br = (o == 6'b000101) ? 2 : 1;
            plan.push_back(e);
        end else if (o == 6'b001000) begin
            plan.push_back(e);
            e = quiet(); e.alusrca = 1; e.alusrcb = 2'b10; plan.push_back(e);
            e = quiet(); e.regwrite = 1; plan.push_back(e);
        end else if (o == 6'b000010) begin
            plan.push_back(e);
            e = quiet(); e.pcsrc = 2'b10; e.pcen = 1; plan.push_back(e);
        end else begin
            e.illegal = 1;
            plan.push_back(e);
        end
    endtask

    task automatic check_cycle(input string tag, input exp_t e, input logic z);
        logic exp_pcen;
        exp_pcen = e.pcen | (e.br == 1 && z) | (e.br == 2 && !z);
        check({tag, "/irwrite"},  irwrite,    e.irwrite);
        check({tag, "/pcen"},     pcen,       exp_pcen);
        check({tag, "/iord"},     iord,       e.iord);
        check({tag, "/memwrite"}, memwrite,   e.memwrite);
        check({tag, "/alusrca"},  alusrca,    e.alusrca);
        check({tag, "/alusrcb"},  alusrcb,    e.alusrcb);
        check({tag, "/pcsrc"},    pcsrc,      e.pcsrc);
        check({tag, "/regdst"},   regdst,     e.regdst);
        check({tag, "/memtoreg"}, memtoreg,   e.memtoreg);
        check({tag, "/regwrite"}, regwrite,   e.regwrite);
        check({tag, "/alu"},      alucontrol, e.alu);
        check({tag, "/illegal"},  illegal_op, e.illegal);
    endtask

    // Entered mid-cycle with the DUT in FETCH; leaves mid-cycle back in FETCH.
    // zmode < 0 randomizes zero every cycle.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f, input int zmode);
        op = o;
        funct = f;
        build_plan(o, f, 1'b1);
        for (int i = 0; i < plan.size(); i++) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_cycle($sformatf("%s/c%0d", name, i), plan[i], zero);
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] op_pool [8];
    logic [5:0] fn_pool [6];

    initial begin
        reset_n = 1'b0;
        op = 6'b0; funct = 6'b0; zero = 1'b0;
        op_pool = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111};
        fn_pool = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b111111};

        repeat (2) @(posedge clk);
        #1;
        check("rst/irwrite",  irwrite,  1'b0);
        check("rst/pcen",     pcen,     1'b0);
        check("rst/regwrite", regwrite, 1'b0);
        check("rst/alusrcb",  alusrcb,  2'b01);
        @(negedge clk);
        reset_n = 1'b1;

        // bne with bne disabled: illegal pulse in decode, then fetch.
        op = OP_BNE; #1;
        check("nobne/fetch_ir", nb_irwrite, 1'b1);
        @(posedge clk); #1;
        check("nobne/illegal",     nb_illegal_op, 1'b1);
        check("nobne/bne_legal",   illegal_op,    1'b0);
        @(posedge clk); #1;
        check("nobne/back_fetch",  nb_irwrite,    1'b1);
        check("nobne/no_illegal",  nb_illegal_op, 1'b0);
        check("nobne/no_regwrite", nb_regwrite,   1'b0);

        // lw interrupted in MEMRD; reset also realigns both instances.
        @(negedge clk);
        reset_n = 1'b0; #1;
        @(negedge clk);
        reset_n = 1'b1;
        op = OP_LW; funct = 6'b0;
        repeat (3) @(posedge clk);
        #1;
        check("lwrst/memrd_iord", iord, 1'b1);
        reset_n = 1'b0; #1;
        check("lwrst/irwrite_low", irwrite, 1'b0);
        check("lwrst/pcen_low",    pcen,    1'b0);
        check("lwrst/iord_low",    iord,    1'b0);
        check("lwrst/alusrcb_low", alusrcb, 2'b01);
        @(posedge clk); #1;
        check("lwrst/held_irwrite", irwrite, 1'b0);
        @(negedge clk);
        reset_n = 1'b1; #1;
        check("lwrst/rel_irwrite", irwrite, 1'b1);
        check("lwrst/rel_pcen",    pcen,    1'b1);
        check("lwrst/rel_alusrcb", alusrcb, 2'b01);

        // Directed instructions.
        run_instr("lw", OP_LW, 6'b0, -1);
        run_instr("sw", OP_SW, 6'b0, -1);
        for (int i = 0; i < 6; i++)
            run_instr($sformatf("rtype%0d", i), OP_RTYPE, fn_pool[i], -1);
        run_instr("beq_z1", OP_BEQ, 6'b0, 1);
        run_instr("beq_z0", OP_BEQ, 6'b0, 0);
        run_instr("bne_z1", OP_BNE, 6'b0, 1);
        run_instr("bne_z0", OP_BNE, 6'b0, 0);
        run_instr("addi",   OP_ADDI, 6'b0, -1);
        run_instr("j",      OP_J, 6'b0, -1);
        run_instr("ill",    6'b111111, 6'b0, -1);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 7)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
            run_instr($sformatf("rnd%0d_op%02h", n, o), o, f, -1);
        end

        #1;
        check("end/fetch", irwrite, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit that produces the 3-bit ALU function code and all datapath enables.
- It sits opposite the ALU on the f/zero interface:
  - it decodes op/funct into f;
  - it consumes the ALU zero flag for branch decisions.
- It also sequences the multicycle datapath: fetch, decode, execute, memory, writeback.

Parameters:
- ENABLE_BNE, 1, when 1 opcode 000101 (bne) is decoded; when 0 it is illegal.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag (ALU result all zeros)
- alucontrol  output  3  ALU f: 010 add, 110 sub, 000 and, 001 or, 111 slt
- alusrca  output  1  0=PC, 1=register A
- alusrcb  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
- pcen  output  1  PC register enable
- iord  output  1  memory address select, 0=PC, 1=ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regdst  output  1  write register select, 0=rt, 1=rd
- memtoreg  output  1  writeback select, 0=ALUOut, 1=data register
- regwrite  output  1  register file write
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Reset:
  - reset_n low forces the state to FETCH asynchronously.
  - While reset_n is low, irwrite, pcen, memwrite, regwrite and illegal_op are forced 0.
  - All other outputs take their FETCH values.
  - Reset may be asserted in any state; the first active edge after release performs FETCH.
- Outputs are Moore outputs, decoded combinationally from the state register. The exceptions are:
  - pcen, which also depends on zero;
  - alucontrol, which also depends on funct.
- aluop encoding: 00 add, 01 sub, 10 use funct.
- FSM states and transitions (all transitions on rising clk):
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1. Next state DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 000101 -> BEQEX when ENABLE_BNE=1
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other op -> FETCH, with illegal_op=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Next state MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
  - MEMWR: iord=1, memwrite=1. Next state FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next state RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
  - JEX: pcsrc=10, pcwrite=1. Next state FETCH.
- Outputs not listed for a state are 0 (alusrcb 00, pcsrc 00).
- pcen = pcwrite | (branch & (zero XOR bne)), where bne = (op==000101).
- alucontrol decode:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010; the instruction still writes back.
- Latency in cycles: lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 2.
- op and funct are sampled only when used. The instruction register holds them stable after FETCH.

Decomposition:
- Package mc_pkg holds:
  - the state_t enum;
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - funct constants;
  - aluop_t;
  - alucontrol constants (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111).
- One sub-module, alu_decoder: inputs aluop and funct, output alucontrol; purely combinational.
- The FSM lives in mc_controller.

Test Plan:
- Reset mid-MEMRD during a lw: pull reset_n low -> state is FETCH immediately; irwrite=0 and pcen=0 while low; after release, next edge is FETCH with irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011): expected state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - MEMADR: alucontrol=010, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0.
  - 5 cycles total.
- R-type (op=0) with funct 100010, 101010, 100100, 100101, 100000, 111111 -> alucontrol in RTYPEEX is 110, 111, 000, 001, 010, 010 respectively; RTYPEWB has regwrite=1, regdst=1.
- beq in BEQEX:
  - zero=1 -> pcen=1, pcsrc=01, alucontrol=110.
  - zero=0 -> pcen=0.
  - bne (ENABLE_BNE=1) gives the inverse.
  - With ENABLE_BNE=0, bne gives illegal_op=1 in DECODE, then FETCH.
- j (op=000010): JEX has pcsrc=10, pcen=1, regwrite=0, memwrite=0; next state FETCH.
- Illegal op=111111: DECODE asserts illegal_op for exactly 1 cycle, then FETCH; no regwrite or memwrite is asserted.
